// File: rtl/test_engine_pipelined_pkg.sv
// Shared constants for the pipelined test engine: channel width and job mode encodings.
package test_engine_pipelined_pkg;

   localparam int CHANNEL_WIDTH = 32;
   localparam int TE_MODE_W     = 2;

   typedef enum logic [TE_MODE_W-1:0] {
      TE_MODE_SWAP  = 2'b00,
      TE_MODE_PASS  = 2'b01,
      TE_MODE_LOGIC = 2'b10,
      TE_MODE_ARITH = 2'b11
   } te_mode_e;

endpackage

// File: rtl/test_engine_job_fifo.sv
// Show-ahead synchronous job FIFO; count doubles as the engine's in-flight occupancy.
module test_engine_job_fifo
   import test_engine_pipelined_pkg::*;
#(
   parameter int WIDTH = 2 + 4 * CHANNEL_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Explicit wrap keeps non-power-of-two-sized pointers (DEPTH=1) correct.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;

   a_no_pop_empty:  assert property (@(posedge clk) disable iff (!reset_n) !(pop && (r_count == '0)));
   a_no_push_full:  assert property (@(posedge clk) disable iff (!reset_n)
                                     !(push && !pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/test_engine_pipelined.sv
// Pipelined test engine: one job per cycle in, results a fixed LATENCY later, up to DEPTH in flight.
module test_engine_pipelined
   import test_engine_pipelined_pkg::*;
#(
   parameter int WORD_WIDTH = 2 * CHANNEL_WIDTH,
   parameter int LATENCY    = 16,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_strobe_din,
   input  logic [TE_MODE_W-1:0]  mode_din,
   input  logic [WORD_WIDTH-1:0] wordA_din,
   input  logic [WORD_WIDTH-1:0] wordB_din,
   output logic                  ready_dout,
   output logic                  active_test_engine_dout,
   output logic                  done_strobe_dout,
   output logic [WORD_WIDTH-1:0] wordC_dout,
   output logic [WORD_WIDTH-1:0] wordD_dout,
   output logic                  overflow_error_dout,
   output logic [CNT_WIDTH-1:0]  completed_count_dout
);

   localparam int JOB_W = TE_MODE_W + 2 * WORD_WIDTH;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic [LATENCY-1:0]    r_vld_pipe;
   logic                  r_done;
   logic [WORD_WIDTH-1:0] r_wordC;
   logic [WORD_WIDTH-1:0] r_wordD;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_overflow;

   logic                  w_ready;
   logic                  w_accept;
   logic                  w_pop;
   logic [OW-1:0]         w_occ;
   logic [JOB_W-1:0]      w_head;
   te_mode_e              w_head_mode;
   logic [WORD_WIDTH-1:0] w_head_a;
   logic [WORD_WIDTH-1:0] w_head_b;
   logic [2*WORD_WIDTH-1:0] w_result;

   function automatic logic [2*WORD_WIDTH-1:0] alu(input te_mode_e m,
                                                   input logic [WORD_WIDTH-1:0] a,
                                                   input logic [WORD_WIDTH-1:0] b);
      logic [2*WORD_WIDTH-1:0] res;
      case (m)
         TE_MODE_SWAP:  res = {b, a};
         TE_MODE_PASS:  res = {a, b};
         TE_MODE_LOGIC: res = {a ^ b, a & b};
         TE_MODE_ARITH: res = {a + b, a - b};
         default:       res = '0;
      endcase
      return res;
   endfunction

   // Ready looks only at registered occupancy, so a same-cycle completion cannot free a slot.
   assign w_ready  = (w_occ < OW'(DEPTH));
   assign w_accept = start_strobe_din & w_ready;
   assign w_pop    = r_vld_pipe[LATENCY-1];

   test_engine_job_fifo #(
      .WIDTH (JOB_W),
      .DEPTH (DEPTH)
   ) u_job_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_accept),
      .pop     (w_pop),
      .din     ({mode_din, wordA_din, wordB_din}),
      .dout    (w_head),
      .count   (w_occ)
   );

   assign w_head_mode = te_mode_e'(w_head[JOB_W-1 -: TE_MODE_W]);
   assign w_head_a    = w_head[2*WORD_WIDTH-1 -: WORD_WIDTH];
   assign w_head_b    = w_head[WORD_WIDTH-1:0];
   assign w_result    = alu(w_head_mode, w_head_a, w_head_b);

   // Valid pipe tracks when each accepted job is due; its tail drives the pop and the result register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_pipe <= '0;
         r_done     <= 1'b0;
         r_wordC    <= '0;
         r_wordD    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[LATENCY-2:0], w_accept};
         r_done     <= w_pop;
         if (w_pop) begin
            r_wordC <= w_result[2*WORD_WIDTH-1 -: WORD_WIDTH];
            r_wordD <= w_result[WORD_WIDTH-1:0];
            r_count <= r_count + CNT_WIDTH'(1);
         end else begin
            r_wordC <= '0;
            r_wordD <= '0;
         end
         if (start_strobe_din && !w_ready) r_overflow <= 1'b1;
      end
   end

   assign ready_dout              = w_ready;
   assign active_test_engine_dout = (w_occ != '0);
   assign done_strobe_dout        = r_done;
   assign wordC_dout              = r_wordC;
   assign wordD_dout              = r_wordD;
   assign overflow_error_dout     = r_overflow;
   assign completed_count_dout    = r_count;

endmodule

// File: tb/tb_test_engine_pipelined.sv
// Scoreboard bench for test_engine_pipelined: a LATENCY=16 instance and a LATENCY=4 instance.
module tb_test_engine_pipelined;
   import test_engine_pipelined_pkg::*;

   localparam int W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] c;
      logic [W-1:0] d;
      int           due;
   } exp_t;

   exp_t q16[$];
   exp_t q4[$];

   logic          rst16_n, st16, rdy16, act16, dn16, ovf16;
   logic [1:0]    md16;
   logic [W-1:0]  a16, b16, c16, d16;
   logic [15:0]   cnt16;

   logic          rst4_n, st4, rdy4, act4, dn4, ovf4;
   logic [1:0]    md4;
   logic [W-1:0]  a4, b4, c4, d4;
   logic [15:0]   cnt4;

   test_engine_pipelined #(.WORD_WIDTH(W), .LATENCY(16), .DEPTH(4), .CNT_WIDTH(16)) u_dut16 (
      .clk(clk), .reset_n(rst16_n), .start_strobe_din(st16), .mode_din(md16),
      .wordA_din(a16), .wordB_din(b16), .ready_dout(rdy16), .active_test_engine_dout(act16),
      .done_strobe_dout(dn16), .wordC_dout(c16), .wordD_dout(d16),
      .overflow_error_dout(ovf16), .completed_count_dout(cnt16)
   );

   test_engine_pipelined #(.WORD_WIDTH(W), .LATENCY(4), .DEPTH(4), .CNT_WIDTH(16)) u_dut4 (
      .clk(clk), .reset_n(rst4_n), .start_strobe_din(st4), .mode_din(md4),
      .wordA_din(a4), .wordB_din(b4), .ready_dout(rdy4), .active_test_engine_dout(act4),
      .done_strobe_dout(dn4), .wordC_dout(c4), .wordD_dout(d4),
      .overflow_error_dout(ovf4), .completed_count_dout(cnt4)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   function automatic logic [2*W-1:0] ref_model(input logic [1:0] m, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      case (m)
         2'b00:   return {b, a};
         2'b01:   return {a, b};
         2'b10:   return {a ^ b, a & b};
         default: return {a + b, a - b};
      endcase
   endfunction

   // Monitors: pop expected results whenever a done strobe is seen; idle outputs must be zero.
   always @(negedge clk) begin
      exp_t e;
      if (dn16 === 1'b1) begin
         if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL strobe16_unexpected: got done with C=%h, expected no done", c16);
         end else begin
            e = q16.pop_front();
            chk("wordC16", c16, e.c);
            chk("wordD16", d16, e.d);
            chk("due16", W'(cyc), W'(e.due));
         end
      end else begin
         chk("idle16", {c16 | d16}, '0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (dn4 === 1'b1) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL strobe4_unexpected: got done with C=%h, expected no done", c4);
         end else begin
            e = q4.pop_front();
            chk("wordC4", c4, e.c);
            chk("wordD4", d4, e.d);
            chk("due4", W'(cyc), W'(e.due));
         end
      end else begin
         chk("idle4", {c4 | d4}, '0);
      end
   end

   task automatic drive16(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d,
                          input bit exp_rdy, input bit track);
      exp_t e;
      @(negedge clk);
      chk("ready16", W'(rdy16), W'(exp_rdy));
      st16 = 1'b1; md16 = m; a16 = a; b16 = b;
      if (exp_rdy && track) begin
         e.c = c; e.d = d; e.due = cyc + 1 + 16;
         q16.push_back(e);
      end
   endtask

   task automatic reset16();
      @(negedge clk);
      rst16_n = 1'b0; st16 = 1'b0;
      q16.delete();
      @(negedge clk);
      rst16_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int act_cnt;
      logic [2*W-1:0] r;
      exp_t e;
      rst16_n = 1'b0; st16 = 1'b1; md16 = 2'b11; a16 = '1; b16 = '1;
      rst4_n  = 1'b0; st4  = 1'b0; md4  = '0;    a4  = '0; b4  = '0;

      // Test 1: reset with start held high
      repeat (3) @(negedge clk);
      chk("rst_ready", W'(rdy16), 1);
      chk("rst_done", W'(dn16), 0);
      chk("rst_active", W'(act16), 0);
      chk("rst_wordC", c16, 0);
      chk("rst_wordD", d16, 0);
      chk("rst_ovf", W'(ovf16), 0);
      chk("rst_count", W'(cnt16), 0);
      chk("rst_ready4", W'(rdy4), 1);
      @(negedge clk);
      st16 = 1'b0; rst16_n = 1'b1; rst4_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_count", W'(cnt16), 0);
      chk("post_rst_active", W'(act16), 0);

      // Test 2: single SWAP
      drive16(2'b00, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
      act_cnt = 0;
      repeat (16) begin
         @(negedge clk);
         st16 = 1'b0;
         if (act16) act_cnt++;
      end
      chk("active_cycles", W'(act_cnt), 16);
      @(negedge clk);
      chk("active_after", W'(act16), 0);
      chk("count_single", W'(cnt16), 1);

      // Test 3: five starts into a four-deep engine
      reset16();
      for (int i = 0; i < 5; i++)
         drive16(2'b01, W'(i + 1), ~W'(i + 1), W'(i + 1), ~W'(i + 1), (i < 4), 1'b1);
      @(negedge clk);
      st16 = 1'b0;
      chk("ovf_set", W'(ovf16), 1);
      chk("ready_full", W'(rdy16), 0);
      repeat (20) @(negedge clk);
      chk("count_four", W'(cnt16), 4);
      chk("ovf_sticky", W'(ovf16), 1);
      chk("ready_drained", W'(rdy16), 1);

      // Test 4: ARITH wrap, LOGIC, PASS
      drive16(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
      drive16(2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
              64'h0FF0_0FF0_0FF0_0FF0, 64'hF000_F000_F000_F000, 1'b1, 1'b1);
      drive16(2'b01, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
      @(negedge clk);
      st16 = 1'b0;
      repeat (20) @(negedge clk);
      chk("count_seven", W'(cnt16), 7);

      // Test 5: reset pulse with two jobs in flight
      reset16();
      drive16(2'b00, 64'h5, 64'h6, 64'h0, 64'h0, 1'b1, 1'b0);
      drive16(2'b11, 64'h7, 64'h8, 64'h0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      st16 = 1'b0;
      chk("inflight_active", W'(act16), 1);
      @(negedge clk);
      rst16_n = 1'b0;
      @(negedge clk);
      rst16_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("flush_count", W'(cnt16), 0);
      chk("flush_ready", W'(rdy16), 1);
      chk("flush_ovf", W'(ovf16), 0);
      chk("flush_active", W'(act16), 0);

      // Test 6: continuous start, LATENCY=4: one reject every fifth cycle
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("ready4", W'(rdy4), W'((i % 5) != 4));
         st4 = 1'b1;
         md4 = 2'(i);
         a4  = {32'h0123_4567, 32'(i)};
         b4  = {32'(i * 7), 32'hFFFF_0000};
         if ((i % 5) != 4) begin
            r = ref_model(md4, a4, b4);
            e.c = r[2*W-1:W]; e.d = r[W-1:0]; e.due = cyc + 1 + 4;
            q4.push_back(e);
         end
      end
      @(negedge clk);
      st4 = 1'b0;
      chk("ovf4", W'(ovf4), 1);
      repeat (10) @(negedge clk);
      chk("count4", W'(cnt4), 16);

      chk("q16_drained", W'(q16.size()), 0);
      chk("q4_drained", W'(q4.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
